// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand bypass and hazard scoreboard over DEPTH post-decode slots
// Ports:
//   clk, rst (async, active-low)            clock and reset
//   issue_*                                 decode-stage instruction fields
//   rf_a, rf_b                              regfile read data for rs1/rs2
//   slot_result                             per-slot result, slot k at [k*XLEN +: XLEN]
//   flush                                   redirect; kills decode and the youngest slots
//   stall                                   hold PC/IF-ID and bubble slot 0
//   fwd_a/fwd_b, sel_a/sel_b                selected operands; sel 0 = regfile, k+1 = slot k
//   stall_cnt                               saturating count of stalled cycles
module fwd_hazard_unit #(
    parameter int XLEN        = 32,
    parameter int AW          = 5,
    parameter int DEPTH       = 3,
    parameter int FLUSH_SLOTS = 2,
    parameter int SCW         = 16,
    localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [AW-1:0]         issue_rd,
    input  logic [LW-1:0]         issue_lat,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic [AW-1:0]         issue_rs1,
    input  logic [AW-1:0]         issue_rs2,
    input  logic [XLEN-1:0]       rf_a,
    input  logic [XLEN-1:0]       rf_b,
    input  logic [DEPTH*XLEN-1:0] slot_result,
    input  logic                  flush,
    output logic                  stall,
    output logic [XLEN-1:0]       fwd_a,
    output logic [XLEN-1:0]       fwd_b,
    output logic [SW-1:0]         sel_a,
    output logic [SW-1:0]         sel_b,
    output logic [SCW-1:0]        stall_cnt
);
    logic [DEPTH-1:0]         v;
    logic [DEPTH-1:0][AW-1:0] rd;
    logic [DEPTH-1:0][LW-1:0] lat;
    logic                     haz_a, haz_b;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    // A not-yet-ready winner reports a hazard and leaves the regfile selected.
    always_comb begin
        sel_a = '0;
        fwd_a = rf_a;
        haz_a = 1'b0;
        sel_b = '0;
        fwd_b = rf_b;
        haz_b = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v[k] && rd[k] == issue_rs1 && issue_rs1 != '0) begin
                haz_a = 32'(lat[k]) > 32'(k);
                sel_a = haz_a ? '0 : SW'(k + 1);
                fwd_a = haz_a ? rf_a : slot_result[k*XLEN +: XLEN];
            end
            if (v[k] && rd[k] == issue_rs2 && issue_rs2 != '0) begin
                haz_b = 32'(lat[k]) > 32'(k);
                sel_b = haz_b ? '0 : SW'(k + 1);
                fwd_b = haz_b ? rf_b : slot_result[k*XLEN +: XLEN];
            end
        end
        stall = issue_valid && !flush && ((issue_use_rs1 && haz_a) || (issue_use_rs2 && haz_b));
    end

    // Slots always advance; a flush kills the entries entering slots 0..FLUSH_SLOTS-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v         <= '0;
            rd        <= '0;
            lat       <= '0;
            stall_cnt <= '0;
        end else begin
            v[0]   <= issue_valid && issue_we && issue_rd != '0 && !stall && !flush;
            rd[0]  <= issue_rd;
            lat[0] <= (32'(issue_lat) > 32'(DEPTH - 1)) ? LW'(DEPTH - 1) : issue_lat;
            for (int k = 1; k < DEPTH; k++) begin
                v[k]   <= v[k-1] && !(flush && k < FLUSH_SLOTS);
                rd[k]  <= rd[k-1];
                lat[k] <= lat[k-1];
            end
            stall_cnt <= stall_cnt + SCW'(stall && stall_cnt != '1);
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks of fwd_hazard_unit against an issue-history model
module tb_fwd_hazard_unit;
    localparam int D  = 3;
    localparam int FS = 2;
    localparam int N  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_we, issue_use_rs1, issue_use_rs2, flush;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic [1:0]  issue_lat;
    logic [31:0] rf_a, rf_b;
    logic [95:0] slot_result;
    logic        stall, s_stall;
    logic [31:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic [1:0]  sel_a, sel_b, s_sel_a, s_sel_b;
    logic [15:0] stall_cnt;
    logic [3:0]  s_stall_cnt;

    fwd_hazard_unit dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .rf_a(rf_a), .rf_b(rf_b), .slot_result(slot_result), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .sel_a(sel_a), .sel_b(sel_b),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    fwd_hazard_unit #(.SCW(4)) u_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .rf_a(rf_a), .rf_b(rf_b), .slot_result(slot_result), .flush(flush),
        .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .sel_a(s_sel_a), .sel_b(s_sel_b),
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: history of what each cycle issued; an instruction issued at cycle c
    // is age t-1-c at cycle t and its result is ready once age >= latency.
    bit acc[N];
    int rdh[N];
    int lath[N];
    bit flh[N];
    int t = 0;
    int base = 0;
    int cnt = 0;
    bit m_stall;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit alive(int c);
        if (c < base || c < 0 || !acc[c]) return 0;
        for (int f = c + 1; f <= c + FS - 1 && f < t; f++)
            if (flh[f]) return 0;
        return 1;
    endfunction

    function automatic int youngest(int rs);
        if (rs == 0) return -1;
        for (int k = 0; k < D; k++)
            if (alive(t - 1 - k) && rdh[t-1-k] == rs) return k;
        return -1;
    endfunction

    task automatic check();
        int ka, kb;
        bit ha, hb;
        ka = youngest(int'(issue_rs1));
        kb = youngest(int'(issue_rs2));
        ha = ka >= 0 && ka < lath[t-1-ka];
        hb = kb >= 0 && kb < lath[t-1-kb];
        m_stall = issue_valid && !flush && ((issue_use_rs1 && ha) || (issue_use_rs2 && hb));
        chk("stall", 64'(stall), 64'(m_stall));
        if (!ha) begin
            chk("sel_a", 64'(sel_a), 64'(ka + 1));
            chk("fwd_a", 64'(fwd_a), ka >= 0 ? 64'(slot_result[ka*32 +: 32]) : 64'(rf_a));
        end
        if (!hb) begin
            chk("sel_b", 64'(sel_b), 64'(kb + 1));
            chk("fwd_b", 64'(fwd_b), kb >= 0 ? 64'(slot_result[kb*32 +: 32]) : 64'(rf_b));
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(cnt > 65535 ? 65535 : cnt));
        chk("sat_cnt", 64'(s_stall_cnt), 64'(cnt > 15 ? 15 : cnt));
    endtask

    task automatic cyc();
        #1 check();
        @(posedge clk);
        acc[t]  = issue_valid && issue_we && issue_rd != 0 && !m_stall && !flush;
        rdh[t]  = int'(issue_rd);
        lath[t] = issue_lat > 2 ? 2 : int'(issue_lat);
        flh[t]  = flush;
        if (m_stall) cnt++;
        t++;
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_rd = 0; issue_lat = 0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; issue_rs1 = 0; issue_rs2 = 0;
        flush = 0; rf_a = $urandom; rf_b = $urandom;
        slot_result = {$urandom, $urandom, $urandom};
    endtask

    task automatic wr(int rd, int lat);
        idle();
        issue_valid = 1; issue_we = 1; issue_rd = 5'(rd); issue_lat = 2'(lat);
    endtask

    initial begin
        idle();
        rst = 0;
        #1 chk("reset_sel_a", 64'(sel_a), 0);
        chk("reset_cnt", 64'(stall_cnt), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        base = t;

        // ALU back-to-back
        wr(5, 0); cyc();
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5; slot_result[31:0] = 7;
        #1 chk("alu_sel", 64'(sel_a), 1);
        chk("alu_fwd", 64'(fwd_a), 7);
        chk("alu_stall", 64'(stall), 0);
        cyc();

        // load-use: one stall cycle then forward from slot 1
        wr(6, 1); cyc();
        idle(); issue_valid = 1; issue_use_rs2 = 1; issue_rs2 = 6;
        #1 chk("lu_stall", 64'(stall), 1);
        cyc();
        slot_result[63:32] = 32'h1234_5678;
        #1 chk("lu_stall2", 64'(stall), 0);
        chk("lu_cnt", 64'(stall_cnt), 1);
        chk("lu_sel", 64'(sel_b), 2);
        chk("lu_fwd", 64'(fwd_b), 32'h1234_5678);
        cyc();

        // youngest wins
        wr(7, 0); cyc();
        idle(); cyc();
        wr(7, 0); cyc();
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 7;
        slot_result = {32'd3, 32'd0, 32'd9};
        #1 chk("yw_sel", 64'(sel_a), 1);
        chk("yw_fwd", 64'(fwd_a), 9);
        cyc();

        // x0 never forwarded; unused hazardous operand does not stall
        wr(0, 0); cyc();
        idle(); issue_valid = 1; issue_use_rs1 = 1;
        #1 chk("x0_sel", 64'(sel_a), 0);
        cyc();
        wr(8, 1); cyc();
        idle(); issue_valid = 1; issue_rs2 = 8;
        #1 chk("unused_stall", 64'(stall), 0);
        cyc();

        // flush during load-use stall kills the young ALU entry
        wr(6, 2); cyc();
        wr(10, 0); cyc();
        idle(); issue_valid = 1; issue_use_rs2 = 1; issue_rs2 = 6;
        #1 chk("fl_prestall", 64'(stall), 1);
        flush = 1;
        #1 chk("fl_stall", 64'(stall), 0);
        cyc();
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 10; issue_use_rs2 = 1; issue_rs2 = 6;
        #1 chk("fl_killed", 64'(sel_a), 0);
        chk("fl_kept", 64'(sel_b), 3);
        cyc();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            issue_valid   = $urandom_range(0, 99) < 85;
            issue_we      = $urandom_range(0, 99) < 70;
            issue_rd      = 5'($urandom_range(0, 5));
            issue_lat     = 2'($urandom_range(0, 3));
            issue_use_rs1 = $urandom_range(0, 99) < 80;
            issue_use_rs2 = $urandom_range(0, 99) < 60;
            issue_rs1     = 5'($urandom_range(0, 5));
            issue_rs2     = 5'($urandom_range(0, 5));
            rf_a = $urandom; rf_b = $urandom;
            slot_result = {$urandom, $urandom, $urandom};
            flush = $urandom_range(0, 99) < 10;
            cyc();
        end

        // asynchronous reset in the middle of a stall
        wr(6, 2); cyc();
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 6;
        #1 chk("rs_prestall", 64'(stall), 1);
        rst = 0;
        cnt = 0;
        #1 chk("rs_stall", 64'(stall), 0);
        chk("rs_sel_a", 64'(sel_a), 0);
        chk("rs_cnt", 64'(stall_cnt), 0);
        chk("rs_sat_cnt", 64'(s_stall_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        base = t;
        for (int i = 0; i < 20; i++) begin
            wr($urandom_range(1, 5), $urandom_range(0, 3));
            issue_use_rs1 = 1; issue_rs1 = 5'($urandom_range(0, 5));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
